// File: rtl/remote_pkg.sv
// Shared definitions for the remote-control key path.
package remote_pkg;

  localparam int KEY_W = 8;

  localparam logic [KEY_W-1:0] NO_KEY = 8'h00;

  typedef enum logic {
    FLT_IDLE = 1'b0,
    FLT_HOLD = 1'b1
  } flt_state_t;

  // Bits needed to hold the value n (at least one bit, so a disabled filter still elaborates).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/remote_key_fifo_if.sv
// Key-consumer handshake: head-of-queue key plus valid/ready.
interface remote_key_fifo_if;
  import remote_pkg::*;

  logic [KEY_W-1:0] key_data;
  logic             key_valid;
  logic             key_ready;

  modport master (output key_data, output key_valid, input key_ready);
  modport slave  (input key_data, input key_valid, output key_ready);

endinterface

// File: rtl/key_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module key_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);

  assign rd_data = mem[rd_ptr[PTR_W-2:0]];
  assign level   = level_q;

  // Pointer and occupancy registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + PTR_W'(1);
        2'b01:   level_q <= level_q - PTR_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset because reads are qualified by empty.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[PTR_W-2:0]] <= wr_data;
  end

endmodule

// File: rtl/remote_key_fifo.sv
// IR remote key front end: one event per decoder strobe, same-key
// auto-repeat suppression, and a small FWFT queue toward the menu logic.
module remote_key_fifo
  import remote_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [KEY_W-1:0]       Tecla_in,
  input  logic                   Ready_in,
  remote_key_fifo_if.master      kif,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int                CNT_W    = cnt_width(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLDOFF_CYCLES);

  logic [1:0]       rst_sync;
  logic             rst_int;
  logic             ready_q;
  logic             key_event;
  flt_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [KEY_W-1:0] last_key, last_key_d;
  logic             accept;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] fifo_head;

  // Reset asserts at once and releases on the second Clock edge after Reset falls.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_int = rst_sync[1];

  // Remember the previous strobe level so a long strobe gives a single event.
  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) ready_q <= 1'b0;
    else         ready_q <= Ready_in;
  end

  assign key_event = Ready_in & ~ready_q;

  // Filter state register.
  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      state    <= FLT_IDLE;
      cnt      <= '0;
      last_key <= NO_KEY;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      last_key <= last_key_d;
    end
  end

  // Filter next state: a repeated key is dropped without reloading the window,
  // so a held button still yields one key per window.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    last_key_d = last_key;
    accept     = 1'b0;
    case (state)
      FLT_IDLE: begin
        if (key_event) begin
          accept     = 1'b1;
          last_key_d = Tecla_in;
          if (HOLDOFF_CYCLES != 0) begin
            state_d = FLT_HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      FLT_HOLD: begin
        if (key_event && (Tecla_in != last_key)) begin
          accept     = 1'b1;
          last_key_d = Tecla_in;
          cnt_d      = CNT_LOAD;
        end else if (cnt <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = FLT_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = FLT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop  = ~fifo_empty & kif.key_ready;
  assign drop = accept & fifo_full & ~pop;

  key_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (rst_int),
    .wr_en   (accept),
    .wr_data (Tecla_in),
    .rd_en   (kif.key_ready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign kif.key_valid = ~fifo_empty;
  assign kif.key_data  = fifo_empty ? NO_KEY : fifo_head;

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int)      overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_remote_key_fifo.sv
// Directed and random stimulus for remote_key_fifo with a queue scoreboard.
module tb_remote_key_fifo;

  localparam int DEPTH = 4;
  localparam int HOLD  = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Tecla_in = 8'h00;
  logic       Ready_in = 1'b0;
  logic [2:0] level;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  remote_key_fifo_if kif ();

  remote_key_fifo #(
    .DEPTH          (DEPTH),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Tecla_in (Tecla_in),
    .Ready_in (Ready_in),
    .kif      (kif),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf   = 1'b0;
  logic       m_rdy_q = 1'b0;
  logic [7:0] m_last  = 8'h00;
  int         m_cyc   = 0;
  int         m_tacc  = -1000;
  int         n_filt  = 0;
  int         n_ovf   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_rdy_q = 1'b0;
    m_last  = 8'h00;
    m_tacc  = -1000;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic rdy, input logic [7:0] key, input logic krdy, input logic clr);
    logic ev, acc, pop, drp;
    Ready_in      = rdy;
    Tecla_in      = key;
    kif.key_ready = krdy;
    ovf_clr       = clr;
    #1;
    chk("sb_key_valid", {31'd0, kif.key_valid}, {31'd0, q.size() != 0});
    chk("sb_key_data", {24'd0, kif.key_data}, (q.size() != 0) ? {24'd0, q[0]} : 32'd0);
    chk("sb_level", {29'd0, level}, q.size());
    chk("sb_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    ev      = rdy & ~m_rdy_q;
    m_rdy_q = rdy;
    pop     = krdy && (q.size() != 0);
    acc     = ev && (((m_cyc - m_tacc) > HOLD) || (key != m_last));
    drp     = 1'b0;
    if (ev && !acc) n_filt++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      m_last = key;
      m_tacc = m_cyc;
      if (q.size() < DEPTH) q.push_back(key);
      else begin
        drp = 1'b1;
        n_ovf++;
      end
    end
    if (drp)      m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge Clock);
    #1;
    m_cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] key;
    int         hi, lo, sel;
    kif.key_ready = 1'b0;

    // Reset
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_key_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("rst_key_data", {24'd0, kif.key_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    Reset = 1'b0;
    idle(3);

    // Wide strobe gives one entry, visible one cycle after the rising edge
    step(1'b1, 8'h45, 1'b0, 1'b0);
    chk("t1_data_lat", {24'd0, kif.key_data}, 32'h45);
    chk("t1_level_lat", {29'd0, level}, 32'd1);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    idle(2);
    chk("t1_single_entry", {29'd0, level}, 32'd1);
    drain(2);

    // Same-key hold-off: strobes at t=0,10,25
    idle(25);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    chk("t2_repeat_dropped", {29'd0, level}, 32'd1);
    idle(14);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    chk("t2_after_window", {29'd0, level}, 32'd2);
    idle(25);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    chk("t2_new_key", {29'd0, level}, 32'd4);
    idle(1);
    drain(5);

    // Overflow with five distinct keys, then pops and clear
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      idle(1);
    end
    chk("t3_level_full", {29'd0, level}, 32'd4);
    chk("t3_overflow_set", {31'd0, overflow}, 32'd1);
    drain(4);
    chk("t3_empty", {31'd0, kif.key_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Push into a full FIFO while popping
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
      idle(1);
    end
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t4_level_kept", {29'd0, level}, 32'd4);
    chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
    chk("t4_new_head", {24'd0, kif.key_data}, 32'h22);
    idle(1);
    drain(5);

    // Reset during a hold-off window with two entries queued
    step(1'b1, 8'h31, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    idle(1);
    chk("t5_queued", {29'd0, level}, 32'd2);
    Reset = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("t5_rst_level", {29'd0, level}, 32'd0);
    model_reset();
    idle(2);
    Reset = 1'b0;
    idle(2);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    chk("t5_same_key_again", {29'd0, level}, 32'd1);
    idle(1);
    drain(2);

    // Random keys and random consumer against the scoreboard
    idle(25);
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 3);
      key = (sel == 3) ? 8'($urandom) : 8'h10 + 8'(sel);
      hi  = $urandom_range(1, 3);
      lo  = $urandom_range(1, 3);
      repeat (hi) step(1'b1, key, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      repeat (lo) step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    drain(6);
    chk("rand_drained", {29'd0, level}, 32'd0);
    $display("random phase: filter drops=%0d overflow drops=%0d", n_filt, n_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/remote_key_fifo.md
# remote_key_fifo

Downstream consumer of the IR remote decoder: turns its multi-cycle key-valid strobe (`Tecla`/`Ready`) into exactly one key event per strobe, suppresses auto-repeat of the same key within a hold-off window, and buffers accepted keys in a small first-word-fall-through FIFO. Application logic (menu/display control) pops keys with a valid/ready handshake.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `HOLDOFF_CYCLES`, default 1000: same-key suppression window, in Clock cycles; 0 disables the filter.
- `Clock`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  reset, asynchronous, active-high; clock Clock.
- `Tecla_in`  in  8  key code from the decoder; valid only while `Ready_in`=1.
- `Ready_in`  in  1  decoder strobe; high for 1 or more consecutive cycles per decoded key.
- `key_data`  out  8  head-of-FIFO key code; 0 when empty.
- `key_valid`  out  1  FIFO not empty.
- `key_ready`  in  1  consumer accepts `key_data`; pop when `key_valid` & `key_ready`.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a filtered key is dropped because the FIFO is full.
- `ovf_clr`  in  1  synchronous clear of `overflow`; set has priority if both occur in the same cycle.

## Operation
- Reset: asserts asynchronously. Internal 2-flop synchronizer; deassertion takes effect on the 2nd Clock edge after `Reset` falls.
- Reset values: `key_data`=0, `key_valid`=0, `level`=0, `overflow`=0, filter FSM in IDLE, `last_key`=0, holdoff counter=0, pointers=0, `ready_q`=0.
- Reset mid-operation flushes the FIFO and filter state. Keys in flight are lost.
- Edge detect: `ready_q` <= `Ready_in`. `event` = `Ready_in` & ~`ready_q`. A strobe of any width yields one event. `Tecla_in` is sampled in the event cycle only.
- Filter FSM, two states:
  - IDLE: the counter is 0. Any event is accepted, and the FSM goes to HOLD with `last_key`<=`Tecla_in` and counter<=`HOLDOFF_CYCLES`. If `HOLDOFF_CYCLES`=0 the FSM stays in IDLE and every event is accepted.
  - HOLD: the counter decrements by 1 each cycle. It goes to IDLE when the counter would reach 0.
  - Event in HOLD with `Tecla_in`==`last_key`: dropped, and the counter is NOT reloaded, so a held key repeats once per window.
  - Event in HOLD with `Tecla_in`!=`last_key`: accepted, `last_key` updated, counter reloaded, FSM stays in HOLD.
  - The filter updates on acceptance even when the FIFO then drops the key.
- FIFO: pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full = MSBs differ and the rest are equal. Empty = the pointers are equal.
  - Push = accepted event & (~full | pop).
  - Accepted event & full & ~pop: key dropped, `overflow` set.
  - Simultaneous push and pop: both are performed and `level` is unchanged, including when the FIFO is full.
  - Pop while empty: ignored.
- `key_data` is driven combinationally from `mem[rd_ptr]`, gated to 0 when empty.

## Timing
- Event to output latency: `Ready_in` first sampled high at edge N, so the entry is written at edge N. `key_valid`=1 and `key_data` are valid after edge N, giving 1 cycle.
- Pop at edge M: the next entry, or `key_valid`=0, is visible after edge M.
- `level` and `overflow` are registered and update at the same edge as the push or pop.
- `key_data` must hold stable while `key_valid`=1 and `key_ready`=0.
- Back-to-back events need `Ready_in` low for at least 1 cycle between them.

## Structure
- Shared package `remote_pkg`:
  - `KEY_W`=8
  - filter state typedef {`FLT_IDLE`, `FLT_HOLD`}
  - `NO_KEY`=8'h00
- Natural sub-module: `key_sync_fifo`, a generic parameterised FWFT FIFO with `level` and full/empty.
- The top level holds the reset synchronizer, edge detect, filter FSM and overflow logic.

## Test plan
- Reset, then one `Ready_in` pulse 3 cycles wide with `Tecla_in`=8'h45, `key_ready`=0: exactly one entry. `key_data`=8'h45, `level`=1 one cycle after the rising edge.
- `HOLDOFF_CYCLES`=20, key 8'h16 strobed at t=0, 10, 25: entries at t=0 and t=25 only. Then 8'h16 then 8'h0C 5 cycles apart: both accepted.
- `DEPTH`=4, `HOLDOFF_CYCLES`=0, 5 distinct keys 8'h01..8'h05, no pops: `level`=4 and `overflow`=1. Pops return 01,02,03,04. `ovf_clr` clears `overflow`.
- FIFO full, new key 8'hAA arrives in the same cycle as a pop: head popped, 8'hAA written, `level` stays 4, `overflow` stays 0.
- `Reset` asserted mid-window with 2 entries queued: `key_valid`=0 and `level`=0 immediately. 2 cycles after release, the same key is accepted again.
- Random `key_ready` with 200 random keys against a scoreboard model: order preserved, with no loss except counted filter and overflow drops.
